// File: rtl/sio_turnaround_port.sv
// Half-duplex single-wire serial port: shift a word out on sio, release the line, shift a reply in.
// Optional even parity on both directions when SIO_TURNAROUND_PARITY_EN is defined.
module sio_turnaround_port #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned TURN  = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] tx_data,
    output logic             busy = 1'b0,
    output logic [WIDTH-1:0] rx_data,
    output logic             rx_valid,
`ifdef SIO_TURNAROUND_PARITY_EN
    output logic             parity_err,
`endif
    inout  wire              sio
);

`ifdef SIO_TURNAROUND_PARITY_EN
    localparam int unsigned PBITS = 1;
`else
    localparam int unsigned PBITS = 0;
`endif
    // Bits per direction, including the parity bit when enabled.
    localparam int unsigned FRAME  = WIDTH + PBITS;
    localparam int unsigned CNTMAX = (FRAME > TURN) ? FRAME : TURN;
    localparam int unsigned CW     = $clog2(CNTMAX + 1);

    typedef enum logic [1:0] {StIdle, StTx, StTurn, StRx} state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             busy_d;
    logic [WIDTH-1:0] rx_data_d;
    logic             rx_valid_d;
    logic             tx_bit;
`ifdef SIO_TURNAROUND_PARITY_EN
    logic             par_q, par_d;
    logic             parity_err_d;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StIdle;
            shreg_q    <= '0;
            cnt_q      <= '0;
            busy       <= 1'b0;
            rx_data    <= '0;
            rx_valid   <= 1'b0;
`ifdef SIO_TURNAROUND_PARITY_EN
            par_q      <= 1'b0;
            parity_err <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            shreg_q    <= shreg_d;
            cnt_q      <= cnt_d;
            busy       <= busy_d;
            rx_data    <= rx_data_d;
            rx_valid   <= rx_valid_d;
`ifdef SIO_TURNAROUND_PARITY_EN
            par_q      <= par_d;
            parity_err <= parity_err_d;
`endif
        end
    end

    always_comb begin
        state_d    = state_q;
        shreg_d    = shreg_q;
        cnt_d      = cnt_q;
        busy_d     = busy;
        rx_data_d  = rx_data;
        rx_valid_d = 1'b0;
`ifdef SIO_TURNAROUND_PARITY_EN
        par_d        = par_q;
        parity_err_d = parity_err;
`endif
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    shreg_d = tx_data;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                    state_d = StTx;
`ifdef SIO_TURNAROUND_PARITY_EN
                    par_d   = ^tx_data;
`endif
                end
            end
            StTx: begin
                shreg_d = {shreg_q[WIDTH-2:0], 1'b0};
                cnt_d   = cnt_q + CW'(1);
                if (cnt_q == CW'(FRAME - 1)) begin
                    cnt_d   = '0;
                    state_d = StTurn;
                end
            end
            StTurn: begin
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(TURN - 1)) begin
                    cnt_d   = '0;
                    state_d = StRx;
                end
            end
            StRx: begin
                cnt_d = cnt_q + CW'(1);
                // Only data bits enter the shift register; a trailing parity bit is checked, not kept.
                if (cnt_q < CW'(WIDTH)) begin
                    shreg_d = {shreg_q[WIDTH-2:0], sio};
                end
                if (cnt_q == CW'(FRAME - 1)) begin
`ifdef SIO_TURNAROUND_PARITY_EN
                    rx_data_d    = shreg_q;
                    parity_err_d = ^{shreg_q, sio};
`else
                    rx_data_d    = {shreg_q[WIDTH-2:0], sio};
`endif
                    rx_valid_d = 1'b1;
                    busy_d     = 1'b0;
                    cnt_d      = '0;
                    state_d    = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

`ifdef SIO_TURNAROUND_PARITY_EN
    assign tx_bit = (cnt_q == CW'(WIDTH)) ? par_q : shreg_q[WIDTH-1];
`else
    assign tx_bit = shreg_q[WIDTH-1];
`endif

    // Driven from registered state only, so start never reaches the pin combinationally.
    assign sio = (state_q == StTx) ? tx_bit : 1'bz;

endmodule
